// File: rtl/pwm_ramp_ctrl.sv
// PWM generator whose duty slews toward a debounced target by at most STEP per period.
// Duty only moves on period boundaries; a fault forces the output off immediately.
module pwm_ramp_ctrl #(
    parameter int PRESCALE = 49,
    parameter int STEP     = 1
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] duty_target,
    input  logic       enable,
    input  logic       fault,
    output logic       pwm_out,
    output logic [7:0] duty_current,
    output logic       busy,
    output logic       period_start,
    output logic       fault_latched
);
    localparam int             PSW    = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PSW-1:0] PS_MAX = PSW'(PRESCALE);
    localparam logic [8:0]     STEP9  = 9'(STEP);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, FAULT} state_t;

    state_t         state, state_n;
    logic [PSW-1:0] psc;
    logic [7:0]     pcnt;
    logic           tick, wrap;
    logic [7:0]     samp, tgt_q, tgt_n;
    logic [7:0]     eff, eff_n, duty_n;
    logic [8:0]     up_sum, dn_sat;
    logic [7:0]     up_val, dn_val;
    logic           pwm_d, busy_d, fl_d;

    assign tick = (psc == PS_MAX);
    assign wrap = tick && (pcnt == 8'hFF);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            psc          <= '0;
            pcnt         <= 8'd0;
            period_start <= 1'b0;
        end else begin
            psc          <= tick ? '0 : psc + PSW'(1);
            if (tick) pcnt <= pcnt + 8'd1;
            period_start <= wrap;
        end
    end

    // Two equal consecutive samples are needed before the target moves.
    assign tgt_n = (duty_target == samp) ? duty_target : tgt_q;
    assign eff   = enable ? tgt_q : 8'd0;
    assign eff_n = enable ? tgt_n : 8'd0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            samp  <= 8'd0;
            tgt_q <= 8'd0;
        end else begin
            samp  <= duty_target;
            tgt_q <= tgt_n;
        end
    end

    // Saturating one-step moves, done in 9 bits so neither direction can wrap.
    always_comb begin
        up_sum = {1'b0, duty_current} + STEP9;
        up_val = (up_sum >= {1'b0, eff}) ? eff : up_sum[7:0];
        dn_sat = ({1'b0, duty_current} > STEP9) ? ({1'b0, duty_current} - STEP9) : 9'd0;
        dn_val = (dn_sat <= {1'b0, eff}) ? eff : dn_sat[7:0];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state        <= IDLE;
            duty_current <= 8'd0;
        end else begin
            state        <= state_n;
            duty_current <= duty_n;
        end
    end

    always_comb begin
        state_n = state;
        duty_n  = duty_current;
        if (fault) begin
            state_n = FAULT;
            duty_n  = 8'd0;
        end else if (wrap) begin
            case (state)
                IDLE: begin
                    if (eff > duty_current) begin
                        duty_n  = up_val;
                        state_n = (up_val == eff) ? IDLE : RAMP_UP;
                    end else if (eff < duty_current) begin
                        duty_n  = dn_val;
                        state_n = (dn_val == eff) ? IDLE : RAMP_DOWN;
                    end
                end
                RAMP_UP: begin
                    // A reversal spends one boundary turning around, without a duty step.
                    if (eff < duty_current) begin
                        state_n = RAMP_DOWN;
                    end else begin
                        duty_n  = up_val;
                        state_n = (up_val == eff) ? IDLE : RAMP_UP;
                    end
                end
                RAMP_DOWN: begin
                    if (eff > duty_current) begin
                        state_n = RAMP_UP;
                    end else begin
                        duty_n  = dn_val;
                        state_n = (dn_val == eff) ? IDLE : RAMP_DOWN;
                    end
                end
                FAULT: begin
                    if (!enable) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_d  = enable && !fault && (pcnt < duty_current);
        busy_d = (state_n == RAMP_UP) || (state_n == RAMP_DOWN) || (duty_n != eff_n);
        fl_d   = (state_n == FAULT);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pwm_out       <= 1'b0;
            busy          <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            pwm_out       <= pwm_d;
            busy          <= busy_d;
            fault_latched <= fl_d;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios plus random target/enable/fault traffic,
// compared every cycle against a period-level behavioural model.
module tb_pwm_ramp_ctrl;
    localparam int PRESCALE = 1;
    localparam int STEP     = 50;
    localparam int PER      = 256 * (PRESCALE + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] duty_target;
    logic       enable, fault;
    logic       pwm_out, busy, period_start, fault_latched;
    logic [7:0] duty_current;

    int n_assert = 0;
    int n_fail   = 0;

    pwm_ramp_ctrl #(.PRESCALE(PRESCALE), .STEP(STEP)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .duty_target  (duty_target),
        .enable       (enable),
        .fault        (fault),
        .pwm_out      (pwm_out),
        .duty_current (duty_current),
        .busy         (busy),
        .period_start (period_start),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    // Model: a cycle count locates period boundaries; at each boundary the duty
    // takes one saturated step toward the goal, a reversal costs one boundary,
    // and a fault parks everything at 0 until a disabled boundary.
    int         m_cnt, m_duty, m_dir, m_goal;  // m_dir: 0 settled, 1 up, 2 down, 3 fault
    logic [7:0] m_prev, m_tgt;
    logic       m_ps;

    function automatic int toward(input int d, input int g);
        if (g > d) return (d + STEP < g) ? d + STEP : g;
        return (d - STEP > g) ? d - STEP : g;
    endfunction

    always_comb m_goal = enable ? int'(m_tgt) : 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_duty <= 0; m_dir <= 0; m_prev <= 8'd0; m_tgt <= 8'd0; m_ps <= 1'b0;
        end else begin
            m_ps   <= (m_cnt == PER - 1);
            m_cnt  <= (m_cnt == PER - 1) ? 0 : m_cnt + 1;
            m_prev <= duty_target;
            if (duty_target == m_prev) m_tgt <= duty_target;
            if (fault) begin
                m_duty <= 0; m_dir <= 3;
            end else if (m_cnt == PER - 1) begin
                if (m_dir == 3) begin
                    if (!enable) m_dir <= 0;
                end else if (m_dir == 1 && m_goal < m_duty) m_dir <= 2;
                else if (m_dir == 2 && m_goal > m_duty) m_dir <= 1;
                else begin
                    m_duty <= toward(m_duty, m_goal);
                    m_dir  <= (toward(m_duty, m_goal) == m_goal) ? 0 : ((m_goal > m_duty) ? 1 : 2);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("duty", 16'(duty_current), 16'(m_duty));
            chk("period_start", 16'(period_start), 16'(m_ps));
            chk("busy", 16'(busy), 16'((m_dir == 1 || m_dir == 2 || m_duty != m_goal) ? 1 : 0));
            chk("fault_latched", 16'(fault_latched), 16'((m_dir == 3) ? 1 : 0));
        end
    endtask

    task automatic wait_bnd();
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (period_start !== 1'b1 && n < 2 * PER);
        chk("boundary_seen", 16'(period_start), 16'd1);
    endtask

    // Call at a boundary; counts pwm highs over the following full period.
    task automatic measure_pwm(input int exp_cnt);
        int cnt;
        cnt = 0;
        for (int i = 0; i < PER; i++) begin
            step(1);
            cnt += int'(pwm_out);
        end
        chk("pwm_count", 16'(cnt), 16'(exp_cnt));
        chk("pwm_window_end", 16'(period_start), 16'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; duty_target = 8'd0; enable = 1'b0; fault = 1'b0;
        #23;
        chk("rst_duty", 16'(duty_current), 16'd0);
        chk("rst_pwm", 16'(pwm_out), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_ps", 16'(period_start), 16'd0);
        chk("rst_fl", 16'(fault_latched), 16'd0);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1; duty_target = 8'd200;

        // Ramp up 0 -> 200 in steps of 50.
        for (int k = 1; k <= 4; k++) begin
            wait_bnd();
            chk("ramp_up", 16'(duty_current), 16'(50 * k));
        end
        chk("busy_settled", 16'(busy), 16'd0);
        measure_pwm(2 * 200);

        // Ramp down 200 -> 10 must stop at the target, not underflow.
        duty_target = 8'd10;
        wait_bnd(); chk("down_150", 16'(duty_current), 16'd150);
        wait_bnd(); chk("down_100", 16'(duty_current), 16'd100);
        wait_bnd(); chk("down_50", 16'(duty_current), 16'd50);
        wait_bnd(); chk("down_10", 16'(duty_current), 16'd10);

        // Full-scale and zero duty, two periods each.
        duty_target = 8'd255;
        for (int k = 0; k < 5; k++) wait_bnd();
        chk("duty_255", 16'(duty_current), 16'd255);
        measure_pwm(2 * 255);
        measure_pwm(2 * 255);
        duty_target = 8'd0;
        for (int k = 0; k < 6; k++) wait_bnd();
        chk("duty_0", 16'(duty_current), 16'd0);
        measure_pwm(0);
        measure_pwm(0);

        // One-cycle glitch on the target at duty 40 is ignored.
        duty_target = 8'd40;
        wait_bnd(); chk("duty_40", 16'(duty_current), 16'd40);
        step(100);
        duty_target = 8'd255;
        step(1);
        duty_target = 8'd40;
        wait_bnd();
        chk("glitch_duty", 16'(duty_current), 16'd40);
        chk("glitch_busy", 16'(busy), 16'd0);

        // Fault mid-period at duty 128.
        duty_target = 8'd128;
        wait_bnd(); chk("to_90", 16'(duty_current), 16'd90);
        wait_bnd(); chk("to_128", 16'(duty_current), 16'd128);
        step(100);
        fault = 1'b1;
        step(1);
        fault = 1'b0;
        chk("fault_pwm", 16'(pwm_out), 16'd0);
        chk("fault_duty", 16'(duty_current), 16'd0);
        chk("fault_fl", 16'(fault_latched), 16'd1);
        wait_bnd(); chk("fault_held_enabled", 16'(fault_latched), 16'd1);
        enable = 1'b0;
        wait_bnd(); chk("fault_exit", 16'(fault_latched), 16'd0);
        enable = 1'b1;
        wait_bnd(); chk("restart_from_0", 16'(duty_current), 16'd50);

        // Enable falling mid-ramp turns the ramp around toward 0.
        step(50);
        enable = 1'b0;
        wait_bnd(); chk("redirect_hold", 16'(duty_current), 16'd50);
        chk("disabled_pwm", 16'(pwm_out), 16'd0);
        wait_bnd(); chk("redirect_zero", 16'(duty_current), 16'd0);

        // Reset mid-ramp, then time the first boundary.
        enable = 1'b1; duty_target = 8'd200;
        wait_bnd(); wait_bnd();
        chk("pre_reset_duty", 16'(duty_current), 16'd100);
        step(77);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_duty", 16'(duty_current), 16'd0);
        chk("mid_rst_pwm", 16'(pwm_out), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_ps", 16'(period_start), 16'd0);
        chk("mid_rst_fl", 16'(fault_latched), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (period_start !== 1'b1 && n < 2 * PER);
        chk("first_ps_after_reset", 16'(n), 16'(PER));

        // Random traffic against the model.
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: duty_target = 8'($urandom_range(0, 255));
                4: begin
                    duty_target = ~duty_target;
                    step(1);
                    duty_target = ~duty_target;
                end
                5, 6: enable = ~enable;
                7: begin
                    fault = 1'b1;
                    step($urandom_range(1, 3));
                    fault = 1'b0;
                end
                default: enable = 1'b1;
            endcase
            step($urandom_range(50, 900));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
